// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer.
// State encoding, round-count constants and the round-key index helper.
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_256 = 14;
    localparam int RND_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY   = 3'd1,
        ST_INIT  = 3'd2,
        ST_MAIN  = 3'd3,
        ST_FINAL = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Encrypt walks keys upward, decrypt walks them down from nr.
    function automatic logic [RND_W-1:0] round_index(
        input logic             enc,
        input logic [RND_W-1:0] rnd,
        input logic [RND_W-1:0] nr
    );
        return enc ? rnd : (nr - rnd);
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: KEY -> INIT -> MAIN -> FINAL -> DONE with key-wait timeout.
// Optional 256-bit key support is enabled with `define AES_ROUND_CTRL_KEY256_EN.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR_DEF      = 10,
    parameter int KEY_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             encdec,
    input  logic             key_ready,
`ifdef AES_ROUND_CTRL_KEY256_EN
    input  logic             keylen,
`endif
    output logic             key_init,
    output logic             init_round,
    output logic             main_round,
    output logic             final_round,
    output logic [RND_W-1:0] round_idx,
    output logic             busy,
    output logic             ready,
    output logic             done,
    output logic             err
);

    localparam logic             TO_EN   = (KEY_TIMEOUT != 0);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(KEY_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [RND_W-1:0]  rnd_q, rnd_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              enc_q, enc_d;
    logic [RND_W-1:0]  nr_q, nr_d;
    logic [RND_W-1:0]  nr_start_s;

    logic              key_init_q, key_init_d;
    logic              init_round_q, init_round_d;
    logic              main_round_q, main_round_d;
    logic              final_round_q, final_round_d;
    logic [RND_W-1:0]  round_idx_q, round_idx_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

`ifdef AES_ROUND_CTRL_KEY256_EN
    assign nr_start_s = keylen ? RND_W'(NR_256) : RND_W'(NR_DEF);
`else
    assign nr_start_s = RND_W'(NR_DEF);
`endif

    // Next-state, counters and the outputs decoded from the next state.
    always_comb begin
        state_d  = state_q;
        rnd_d    = rnd_q;
        to_cnt_d = to_cnt_q;
        enc_d    = enc_q;
        nr_d     = nr_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rnd_d    = 4'd0;
                to_cnt_d = TO_W'(0);
                if (start) begin
                    enc_d   = encdec;
                    nr_d    = nr_start_s;
                    state_d = ST_KEY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEY: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (key_ready) begin
                    state_d = ST_INIT;
                    rnd_d   = 4'd0;
                end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_KEY;
                end
            end
            ST_INIT: begin
                rnd_d   = 4'd1;
                state_d = ST_MAIN;
            end
            ST_MAIN: begin
                if (rnd_q == (nr_q - 4'd1)) begin
                    rnd_d   = nr_q;
                    state_d = ST_FINAL;
                end else begin
                    rnd_d   = rnd_q + 4'd1;
                end
            end
            ST_FINAL: state_d = ST_DONE;
            ST_DONE: begin
                rnd_d   = 4'd0;
                state_d = ST_IDLE;
            end
            default: begin
                rnd_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the Moore decode of the next state.
        key_init_d    = (state_d == ST_KEY) && (state_q != ST_KEY);
        init_round_d  = (state_d == ST_INIT);
        main_round_d  = (state_d == ST_MAIN);
        final_round_d = (state_d == ST_FINAL);
        busy_d        = (state_d == ST_KEY) || (state_d == ST_INIT) ||
                        (state_d == ST_MAIN) || (state_d == ST_FINAL);
        ready_d       = (state_d == ST_IDLE);
        done_d        = (state_d == ST_DONE);
        if ((state_d == ST_INIT) || (state_d == ST_MAIN) || (state_d == ST_FINAL)) begin
            round_idx_d = round_index(enc_d, rnd_d, nr_d);
        end else begin
            round_idx_d = 4'd0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rnd_q         <= 4'd0;
            to_cnt_q      <= TO_W'(0);
            enc_q         <= 1'b0;
            nr_q          <= RND_W'(NR_DEF);
            key_init_q    <= 1'b0;
            init_round_q  <= 1'b0;
            main_round_q  <= 1'b0;
            final_round_q <= 1'b0;
            round_idx_q   <= 4'd0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rnd_q         <= rnd_d;
            to_cnt_q      <= to_cnt_d;
            enc_q         <= enc_d;
            nr_q          <= nr_d;
            key_init_q    <= key_init_d;
            init_round_q  <= init_round_d;
            main_round_q  <= main_round_d;
            final_round_q <= final_round_d;
            round_idx_q   <= round_idx_d;
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign key_init    = key_init_q;
    assign init_round  = init_round_q;
    assign main_round  = main_round_q;
    assign final_round = final_round_q;
    assign round_idx   = round_idx_q;
    assign busy        = busy_q;
    assign ready       = ready_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: directed table, corner sequences, random vs model.
module tb_aes_round_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, encdec = 1'b0, key_ready = 1'b0, keylen = 1'b0;
    logic       key_init, init_round, main_round, final_round, busy, ready, done, err;
    logic [3:0] round_idx;

    int n_cmp = 0, n_bad = 0;
    int dut_dones = 0;

    // model: phase 0 idle, 1 key wait, 2 rounds (k = cycles since INIT)
    int m_phase = 0, m_kc = 0, m_k = 0, m_nr = 10, m_dones = 0;
    bit m_enc = 1'b0, m_err = 1'b0;

    aes_round_ctrl #(.NR_DEF(10), .KEY_TIMEOUT(TO), .TO_W(7)) dut (
        .clk(clk), .rst(rst), .start(start), .encdec(encdec), .key_ready(key_ready),
`ifdef AES_ROUND_CTRL_KEY256_EN
        .keylen(keylen),
`endif
        .key_init(key_init), .init_round(init_round), .main_round(main_round),
        .final_round(final_round), .round_idx(round_idx), .busy(busy), .ready(ready),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] dut_vec();
        return {key_init, init_round, main_round, final_round, round_idx, busy, ready, done, err};
    endfunction

    function automatic logic [11:0] model_out();
        logic       ki, ir, mr, fr, bz, rd, dn;
        logic [3:0] idx;
        ki  = (m_phase == 1) && (m_kc == 0);
        ir  = (m_phase == 2) && (m_k == 0);
        mr  = (m_phase == 2) && (m_k >= 1) && (m_k <= m_nr - 1);
        fr  = (m_phase == 2) && (m_k == m_nr);
        bz  = (m_phase == 1) || ((m_phase == 2) && (m_k <= m_nr));
        rd  = (m_phase == 0);
        dn  = (m_phase == 2) && (m_k == m_nr + 1);
        idx = ((m_phase == 2) && (m_k <= m_nr)) ? 4'(m_enc ? m_k : m_nr - m_k) : 4'd0;
        return {ki, ir, mr, fr, idx, bz, rd, dn, m_err};
    endfunction

    task automatic model_step(input bit r, input bit s, input bit e, input bit kr, input bit kl);
        m_err = 1'b0;
        if (r) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (s) begin
                m_phase = 1; m_kc = 0; m_enc = e;
`ifdef AES_ROUND_CTRL_KEY256_EN
                m_nr = kl ? 14 : 10;
`else
                m_nr = 10;
`endif
            end
        end else if (m_phase == 1) begin
            if (kr) begin
                m_phase = 2; m_k = 0;
            end else if (m_kc == TO - 1) begin
                m_phase = 0; m_err = 1'b1;
            end else begin
                m_kc++;
            end
        end else begin
            if (m_k == m_nr + 1) m_phase = 0;
            else begin
                m_k++;
                if (m_k == m_nr + 1) m_dones++;
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input bit r, input bit s, input bit e, input bit kr, input bit kl);
        rst = r; start = s; encdec = e; key_ready = kr; keylen = kl;
        @(posedge clk);
        model_step(r, s, e, kr, kl);
        @(negedge clk);
        check("cycle_outputs", 32'(dut_vec()), 32'(model_out()));
        if (done) dut_dones++;
    endtask

    // One transaction; key_ready rises after w low KEY cycles (w >= 99 means never).
    task automatic run_txn(input bit e, input bit kl, input int w,
                           output int done_at, output int err_at,
                           output int idx_first, output int idx_last);
        done_at = -1; err_at = -1; idx_first = -1; idx_last = -1;
        for (int c = 0; c < 40 && done_at < 0 && err_at < 0; c++) begin
            tick(1'b0, c == 0, e, c >= w + 1, kl);
            if (init_round)  idx_first = int'(round_idx);
            if (final_round) idx_last  = int'(round_idx);
            if (done) done_at = c + 1;
            if (err)  err_at  = c + 1;
        end
        tick(1'b0, 1'b0, e, 1'b0, kl);
        check("ready_after_end", 32'(ready), 32'd1);
    endtask

    typedef struct {
        bit enc; bit kl; int w;
        int exp_done; int exp_err; int exp_first; int exp_last;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int d, er, f, l, dones0;

        vecs.push_back('{1'b1, 1'b0, 0,  13, -1,  0, 10});
        vecs.push_back('{1'b0, 1'b0, 0,  13, -1, 10,  0});
        vecs.push_back('{1'b1, 1'b0, 5,  18, -1,  0, 10});
        vecs.push_back('{1'b0, 1'b0, 7,  20, -1, 10,  0});
        vecs.push_back('{1'b1, 1'b0, 99, -1,  9, -1, -1});
`ifdef AES_ROUND_CTRL_KEY256_EN
        vecs.push_back('{1'b1, 1'b1, 0,  17, -1,  0, 14});
        vecs.push_back('{1'b0, 1'b1, 3,  20, -1, 14,  0});
`endif

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_state", 32'(dut_vec()), 32'h004);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        foreach (vecs[i]) begin
            run_txn(vecs[i].enc, vecs[i].kl, vecs[i].w, d, er, f, l);
            check($sformatf("v%0d_done_cycle", i), 32'(d), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_err_cycle", i),  32'(er), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_first_idx", i),  32'(f), 32'(vecs[i].exp_first));
            check($sformatf("v%0d_final_idx", i),  32'(l), 32'(vecs[i].exp_last));
        end

        // Starts while busy and during DONE are dropped.
        dones0 = dut_dones;
        for (int c = 0; c < 20; c++) tick(1'b0, (c == 0) || (c == 5) || (c == 13), 1'b1, 1'b1, 1'b0);
        check("one_done_per_start", 32'(dut_dones - dones0), 32'd1);

        // Reset in the middle of MAIN, then a clean transaction.
        for (int c = 0; c < 6; c++) tick(1'b0, c == 0, 1'b1, 1'b1, 1'b0);
        check("mid_main_round4", 32'(round_idx), 32'd4);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_mid_main", 32'(dut_vec()), 32'h004);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 2, d, er, f, l);
        check("after_rst_done_cycle", 32'(d), 32'd15);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int c = 0; c < 30; c++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("total_dones", 32'(dut_dones), 32'(m_dones));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
